sweep_scheduler: RTL and testbench

Sequences a two-axis raster sweep of the sunflower panel mount and samples the panel's ADC at each grid point. It records the peak 12-bit voltage and the (theta, phi) angle where that peak occurred. After the sweep it drives the servos to the best angle and asserts done. It sits between the ADC interface, the servo PWM generators and the BCD/7-segment display path.

---
 rtl/sweep_scheduler.sv | 278 +++++++++++++++++++++++++++
 tb/tb_sweep_scheduler.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_scheduler.sv
// sweep_scheduler: raster sweep of a two-axis panel mount with peak tracking.
//
// Steps theta (inner axis) and phi (outer axis) over a THETA_STEPS x PHI_STEPS
// grid spaced STEP_DEG degrees apart. At every point it waits SETTLE_CYCLES
// clocks for the mount to come to rest and then takes one ADC conversion. The
// largest sample and its angles are kept. The first sample of a sweep always
// wins, and ties keep the earlier point. After the last point the mount is
// driven to the best angle, allowed to settle, and the block parks in DONE.
//
// Optional feature (compile-time macro AUTO_RESWEEP_EN): when defined, DONE
// starts a new sweep by itself after RESWEEP_CYCLES clocks.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   start        one-cycle pulse, starts a sweep from IDLE or DONE
//   abort        level, returns to IDLE at the next edge (beats start)
//   adc_valid    qualifies adc_data for one cycle
//   adc_data     ADC conversion result
//   adc_req      conversion request, held until adc_valid
//   theta, phi   commanded angles (degrees)
//   max_value    peak sample of the current or last sweep
//   best_theta   theta at the peak
//   best_phi     phi at the peak
//   busy         high outside IDLE and DONE
//   done         high in DONE
module sweep_scheduler #(
  parameter int unsigned ADC_W          = 12,
  parameter int unsigned ANG_W          = 8,
  parameter int unsigned THETA_STEPS    = 7,
  parameter int unsigned PHI_STEPS      = 4,
  parameter int unsigned STEP_DEG       = 30,
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned RESWEEP_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  output logic             adc_req,
  output logic [ANG_W-1:0] theta,
  output logic [ANG_W-1:0] phi,
  output logic [ADC_W-1:0] max_value,
  output logic [ANG_W-1:0] best_theta,
  output logic [ANG_W-1:0] best_phi,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TI_W  = (THETA_STEPS > 1) ? $clog2(THETA_STEPS) : 1;
  localparam int unsigned PI_W  = (PHI_STEPS > 1) ? $clog2(PHI_STEPS) : 1;
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [TI_W-1:0]  TI_LAST     = TI_W'(THETA_STEPS - 1);
  localparam logic [PI_W-1:0]  PI_LAST     = PI_W'(PHI_STEPS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  // Reject parameter sets the datapath cannot represent.
  if (THETA_STEPS < 2 || PHI_STEPS < 2 || SETTLE_CYCLES < 1 || RESWEEP_CYCLES < 1 ||
      (THETA_STEPS - 1) * STEP_DEG >= (64'd1 << ANG_W) ||
      (PHI_STEPS - 1) * STEP_DEG >= (64'd1 << ANG_W)) begin : g_bad_cfg
    $error("sweep_scheduler: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_SETTLE,
    S_REQ,
    S_EVAL,
    S_GOTO,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [TI_W-1:0]  ti_q, ti_d;
  logic [PI_W-1:0]  pi_q, pi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             goto_q, goto_d;
  logic [ADC_W-1:0] sample_q, sample_d;
  logic [ANG_W-1:0] theta_q, theta_d;
  logic [ANG_W-1:0] phi_q, phi_d;
  logic [ADC_W-1:0] max_q, max_d;
  logic [ANG_W-1:0] best_theta_q, best_theta_d;
  logic [ANG_W-1:0] best_phi_q, best_phi_d;
  logic             adc_req_q, adc_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             launch;

`ifdef AUTO_RESWEEP_EN
  localparam int unsigned RS_W = (RESWEEP_CYCLES > 1) ? $clog2(RESWEEP_CYCLES) : 1;
  localparam logic [RS_W-1:0] RS_LAST = RS_W'(RESWEEP_CYCLES - 1);

  logic [RS_W-1:0] rs_cnt_q, rs_cnt_d;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ti_q         <= '0;
      pi_q         <= '0;
      cnt_q        <= '0;
      first_q      <= 1'b0;
      goto_q       <= 1'b0;
      sample_q     <= '0;
      theta_q      <= '0;
      phi_q        <= '0;
      max_q        <= '0;
      best_theta_q <= '0;
      best_phi_q   <= '0;
      adc_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ti_q         <= ti_d;
      pi_q         <= pi_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      goto_q       <= goto_d;
      sample_q     <= sample_d;
      theta_q      <= theta_d;
      phi_q        <= phi_d;
      max_q        <= max_d;
      best_theta_q <= best_theta_d;
      best_phi_q   <= best_phi_d;
      adc_req_q    <= adc_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef AUTO_RESWEEP_EN
  // Idle time spent in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_cnt_q <= '0;
    end else begin
      rs_cnt_q <= rs_cnt_d;
    end
  end
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    ti_d         = ti_q;
    pi_d         = pi_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    goto_d       = goto_q;
    sample_d     = sample_q;
    theta_d      = theta_q;
    phi_d        = phi_q;
    max_d        = max_q;
    best_theta_d = best_theta_q;
    best_phi_d   = best_phi_q;
    launch       = 1'b0;
`ifdef AUTO_RESWEEP_EN
    rs_cnt_d     = rs_cnt_q;
`endif

    if (abort) begin
      // Abort beats everything; results and angles are left as they are.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          launch = start;
        end

        S_MOVE: begin
          theta_d = ANG_W'(32'(ti_q) * STEP_DEG);
          phi_d   = ANG_W'(32'(pi_q) * STEP_DEG);
          cnt_d   = SETTLE_LOAD;
          state_d = S_SETTLE;
        end

        // Shared by grid points and the final move to the best angle.
        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = goto_q ? S_DONE : S_REQ;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        S_REQ: begin
          if (adc_valid) begin
            sample_d = adc_data;
            state_d  = S_EVAL;
          end
        end

        S_EVAL: begin
          if (first_q || (sample_q > max_q)) begin
            max_d        = sample_q;
            best_theta_d = theta_q;
            best_phi_d   = phi_q;
          end
          first_d = 1'b0;
          // Theta is the inner axis.
          if (ti_q != TI_LAST) begin
            ti_d    = ti_q + TI_W'(1);
            state_d = S_MOVE;
          end else if (pi_q != PI_LAST) begin
            ti_d    = '0;
            pi_d    = pi_q + PI_W'(1);
            state_d = S_MOVE;
          end else begin
            state_d = S_GOTO;
          end
        end

        S_GOTO: begin
          theta_d = best_theta_q;
          phi_d   = best_phi_q;
          cnt_d   = SETTLE_LOAD;
          goto_d  = 1'b1;
          state_d = S_SETTLE;
        end

        S_DONE: begin
          if (start) begin
            launch = 1'b1;
          end
`ifdef AUTO_RESWEEP_EN
          else if (rs_cnt_q == RS_LAST) begin
            launch = 1'b1;
          end else begin
            rs_cnt_d = rs_cnt_q + RS_W'(1);
          end
`endif
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase

      // Sweep launch: fresh indices, cleared peak, first sample always wins.
      if (launch) begin
        ti_d    = '0;
        pi_d    = '0;
        max_d   = '0;
        first_d = 1'b1;
        goto_d  = 1'b0;
        state_d = S_MOVE;
      end
    end

`ifdef AUTO_RESWEEP_EN
    if (state_d != S_DONE) begin
      rs_cnt_d = '0;
    end
`endif

    // Status flags track the state being entered so they line up with it.
    adc_req_d = (state_d == S_REQ);
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
  end

  assign adc_req    = adc_req_q;
  assign theta      = theta_q;
  assign phi        = phi_q;
  assign max_value  = max_q;
  assign best_theta = best_theta_q;
  assign best_phi   = best_phi_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sweep_scheduler.sv
// Testbench for sweep_scheduler: 4x3 grid, 30 degree steps, 2 settle cycles.
// A panel/ADC model answers conversion requests from a table indexed by the
// commanded angles; a reference model tracks raster order, peak and timing.
`timescale 1ns/1ps
module tb_sweep_scheduler;

  localparam int ADC_W   = 12;
  localparam int ANG_W   = 8;
  localparam int TS      = 4;
  localparam int PS      = 3;
  localparam int STEP    = 30;
  localparam int SETTLE  = 2;
  localparam int RESWEEP = 10;
  localparam int NPTS    = TS * PS;
  localparam int GAP     = 2 + SETTLE;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             adc_valid = 1'b0;
  logic [ADC_W-1:0] adc_data = '0;
  logic             adc_req;
  logic [ANG_W-1:0] theta;
  logic [ANG_W-1:0] phi;
  logic [ADC_W-1:0] max_value;
  logic [ANG_W-1:0] best_theta;
  logic [ANG_W-1:0] best_phi;
  logic             busy;
  logic             done;

  sweep_scheduler #(
    .ADC_W(ADC_W), .ANG_W(ANG_W), .THETA_STEPS(TS), .PHI_STEPS(PS),
    .STEP_DEG(STEP), .SETTLE_CYCLES(SETTLE), .RESWEEP_CYCLES(RESWEEP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .adc_valid(adc_valid), .adc_data(adc_data), .adc_req(adc_req),
    .theta(theta), .phi(phi), .max_value(max_value),
    .best_theta(best_theta), .best_phi(best_phi), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Panel response table, indexed [theta/STEP][phi/STEP].
  int unsigned vtab [TS][PS];

  // ADC model configuration.
  int delay_cfg = 0;
  int stall_idx = -1;
  int stall_len = 0;
  bit spur_en   = 1'b0;
  bit spur_tog  = 1'b0;
  int wait_cnt  = 0;

  // Reference model of the sweep in progress.
  int          hs_idx = 0;
  int unsigned m_max = 0;
  int          m_bt = 0;
  int          m_bp = 0;
  bit          m_first = 1'b1;
  bit          m_abort = 1'b0;
  bit          prev_req = 1'b0;
  bit          prev_done = 1'b0;
  bit          gap_on = 1'b0;
  int          gap = 0;
  int          req_len = 0;
  int          max_req_len = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int exp_delay(input int k);
    return (k == stall_idx) ? stall_len : delay_cfg;
  endfunction

  function automatic void model_launch();
    hs_idx      = 0;
    m_max       = 0;
    m_first     = 1'b1;
    m_abort     = 1'b0;
    gap_on      = 1'b0;
    max_req_len = 0;
  endfunction

  // Per-cycle comparison against the model, then the ADC model's drive.
  task automatic cycle_step();
    int unsigned v;
    int tix;
    int pix;
    if (!reset) begin
      prev_req  = 1'b0;
      prev_done = 1'b0;
      gap_on    = 1'b0;
      wait_cnt  = 0;
      adc_valid = 1'b0;
      return;
    end
    if (gap_on) gap++;
    if (adc_req && !prev_req) begin
      if (hs_idx >= NPTS) check("extra_req", 32'(hs_idx), 32'(NPTS - 1));
      check("req_theta", 32'(theta), 32'((hs_idx % TS) * STEP));
      check("req_phi", 32'(phi), 32'((hs_idx / TS) * STEP));
      check("req_max", 32'(max_value), m_max);
      if (hs_idx > 0) begin
        check("req_best_theta", 32'(best_theta), 32'(m_bt));
        check("req_best_phi", 32'(best_phi), 32'(m_bp));
      end
      if (gap_on) check("settle_gap", 32'(gap), 32'(GAP));
      gap_on  = 1'b0;
      req_len = 1;
    end else if (adc_req) begin
      req_len++;
      check("hold_theta", 32'(theta), 32'((hs_idx % TS) * STEP));
      check("hold_phi", 32'(phi), 32'((hs_idx / TS) * STEP));
    end else if (prev_req && !m_abort) begin
      // Request dropped: the sample for raster point hs_idx was taken.
      check("req_len", 32'(req_len), 32'(exp_delay(hs_idx) + 1));
      if (req_len > max_req_len) max_req_len = req_len;
      if (hs_idx < NPTS) begin
        v = vtab[hs_idx % TS][hs_idx / TS];
        if (m_first || v > m_max) begin
          m_max = v;
          m_bt  = (hs_idx % TS) * STEP;
          m_bp  = (hs_idx / TS) * STEP;
        end
      end
      m_first = 1'b0;
      hs_idx++;
      gap     = 0;
      gap_on  = 1'b1;
    end
    if (done && !prev_done) begin
      check("done_busy", 32'(busy), 32'(0));
      check("done_count", 32'(hs_idx), 32'(NPTS));
      check("done_max", 32'(max_value), m_max);
      check("done_best_theta", 32'(best_theta), 32'(m_bt));
      check("done_best_phi", 32'(best_phi), 32'(m_bp));
      check("done_theta", 32'(theta), 32'(m_bt));
      check("done_phi", 32'(phi), 32'(m_bp));
      if (gap_on) check("goto_gap", 32'(gap), 32'(GAP));
      gap_on = 1'b0;
    end
    prev_req  = adc_req;
    prev_done = done;

    adc_valid = 1'b0;
    if (adc_req) begin
      if (wait_cnt >= exp_delay(hs_idx)) begin
        tix = int'(theta) / STEP;
        pix = int'(phi) / STEP;
        adc_valid = 1'b1;
        adc_data  = (tix < TS && pix < PS) ? ADC_W'(vtab[tix][pix]) : '0;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      if (spur_en && busy) begin
        spur_tog = !spur_tog;
        if (spur_tog) begin
          adc_valid = 1'b1;
          adc_data  = '1;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_step();
    #1;
  endtask

  task automatic set_all(input int unsigned v);
    for (int t = 0; t < TS; t++)
      for (int p = 0; p < PS; p++)
        vtab[t][p] = v;
  endtask

  task automatic do_start();
    model_launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      if (done) break;
      tick();
    end
    check("sweep_done", 32'(done), 32'(1));
  endtask

  task automatic wait_req(input int k);
    for (int i = 0; i < 3000; i++) begin
      if (adc_req && hs_idx == k) break;
      tick();
    end
    check("reach_req", 32'(adc_req && hs_idx == k), 32'(1));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_adc_req"}, 32'(adc_req), 32'(0));
    check({tag, "_theta"}, 32'(theta), 32'(0));
    check({tag, "_phi"}, 32'(phi), 32'(0));
    check({tag, "_max"}, 32'(max_value), 32'(0));
    check({tag, "_best_theta"}, 32'(best_theta), 32'(0));
    check({tag, "_best_phi"}, 32'(best_phi), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int bad;
    int cyc;

    // Power-on reset.
    #1 reset = 1'b0;
    tick(); tick();
    check_zero("por");
    reset = 1'b1;
    tick(); tick();
    check("por_idle_busy", 32'(busy), 32'(0));

    // Full sweep, single peak at (60,30).
    set_all(100);
    vtab[2][1] = 900;
    do_start();
    wait_done();
    check("s2_max", 32'(max_value), 32'(900));
    check("s2_best_theta", 32'(best_theta), 32'(60));
    check("s2_best_phi", 32'(best_phi), 32'(30));
    check("s2_theta", 32'(theta), 32'(60));
    check("s2_phi", 32'(phi), 32'(30));
    check("s2_samples", 32'(hs_idx), 32'(12));

    // All-zero sweep: the first sample sets the best point.
    set_all(0);
    do_start();
    wait_done();
    check("s3a_max", 32'(max_value), 32'(0));
    check("s3a_best_theta", 32'(best_theta), 32'(0));
    check("s3a_best_phi", 32'(best_phi), 32'(0));

    // Tie: the earlier point keeps the peak.
    vtab[1][0] = 500;
    vtab[3][2] = 500;
    delay_cfg  = 1;
    do_start();
    wait_done();
    check("s3b_max", 32'(max_value), 32'(500));
    check("s3b_best_theta", 32'(best_theta), 32'(30));
    check("s3b_best_phi", 32'(best_phi), 32'(0));

    // Stalled handshake plus spurious valid pulses outside REQ.
    set_all(100);
    vtab[0][2] = 700;
    delay_cfg  = 0;
    stall_idx  = 5;
    stall_len  = 20;
    spur_en    = 1'b1;
    do_start();
    wait_done();
    check("s4_max", 32'(max_value), 32'(700));
    check("s4_best_theta", 32'(best_theta), 32'(0));
    check("s4_best_phi", 32'(best_phi), 32'(60));
    check("s4_samples", 32'(hs_idx), 32'(12));
    check("s4_longest_req", 32'(max_req_len), 32'(21));
    spur_en   = 1'b0;
    stall_idx = -1;

    // Abort at the 7th request, then restart.
    for (int t = 0; t < TS; t++)
      for (int p = 0; p < PS; p++)
        vtab[t][p] = 100 + 10 * (p * TS + t);
    delay_cfg = 2;
    do_start();
    wait_req(6);
    m_abort = 1'b1;
    abort   = 1'b1;
    tick();
    abort = 1'b0;
    check("s5_req", 32'(adc_req), 32'(0));
    check("s5_busy", 32'(busy), 32'(0));
    check("s5_done", 32'(done), 32'(0));
    check("s5_max_hold", 32'(max_value), 32'(150));
    check("s5_best_theta", 32'(best_theta), 32'(30));
    check("s5_best_phi", 32'(best_phi), 32'(30));
    check("s5_theta_hold", 32'(theta), 32'(60));
    check("s5_phi_hold", 32'(phi), 32'(30));
    adc_valid = 1'b1;
    adc_data  = '1;
    tick();
    check("s5_late_valid_busy", 32'(busy), 32'(0));
    check("s5_late_valid_max", 32'(max_value), 32'(150));
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("s5_abort_wins_busy", 32'(busy), 32'(0));
    check("s5_abort_wins_max", 32'(max_value), 32'(150));
    do_start();
    check("s5_restart_busy", 32'(busy), 32'(1));
    check("s5_restart_max", 32'(max_value), 32'(0));
    wait_done();
    check("s5_final_max", 32'(max_value), 32'(210));
    check("s5_final_best_theta", 32'(best_theta), 32'(90));
    check("s5_final_best_phi", 32'(best_phi), 32'(60));
    delay_cfg = 0;

    // Reset in the middle of SETTLE.
    set_all(100);
    do_start();
    for (int i = 0; i < 3000; i++) begin
      if (hs_idx == 5) break;
      tick();
    end
    check("s1_reach_pt5", 32'(hs_idx), 32'(5));
    tick(); tick();
    check("s1_settle_theta", 32'(theta), 32'(30));
    check("s1_settle_phi", 32'(phi), 32'(30));
    check("s1_settle_busy", 32'(busy), 32'(1));
    reset = 1'b0;
    #1;
    check_zero("s1_async");
    tick();
    reset = 1'b1;
    tick(); tick(); tick();
    check("s1_post_busy", 32'(busy), 32'(0));
    check("s1_post_done", 32'(done), 32'(0));
    check("s1_post_req", 32'(adc_req), 32'(0));

    // Completion behaviour of DONE.
    set_all(100);
    vtab[2][1] = 900;
    do_start();
    wait_done();
`ifdef AUTO_RESWEEP_EN
    cyc = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy) break;
      if (done) cyc++;
    end
    check("s6_done_cycles", 32'(cyc), 32'(RESWEEP));
    check("s6_resweep_busy", 32'(busy), 32'(1));
    check("s6_resweep_done", 32'(done), 32'(0));
    model_launch();
    wait_done();
    check("s6_resweep_max", 32'(max_value), 32'(900));
    bad = 0;
`else
    bad = 0;
    cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      cyc++;
      if (!done || busy || theta != 8'd60 || phi != 8'd30) bad++;
    end
    check("s6_hold_cycles", 32'(cyc), 32'(1000));
`endif
    check("s6_done_hold_bad", 32'(bad), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
